// File: rtl/rf_wb_arbiter_if.sv
// ============================================================================
// Module   : rf_wb_arbiter_if
// Purpose  : Writeback request / register-file write bundle for rf_wb_arbiter.
//            Forwarding signals exist only when RF_WB_FWD_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rf_wb_arbiter_if #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int CW   = 16
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_waddr;
  logic [NREQ*DW-1:0] req_wdata;
  logic               hold;
  logic               rf_we;
  logic [AW-1:0]      rf_waddr;
  logic [DW-1:0]      rf_wdata;
  logic [IDW-1:0]     grant_id;
  logic [CW-1:0]      commit_cnt;
`ifdef RF_WB_FWD_EN
  logic [AW-1:0]      fwd_raddr;
  logic               fwd_hit;
  logic [DW-1:0]      fwd_data;
  logic               fwd_pending;

  modport master (
    output req_valid, req_waddr, req_wdata, hold, fwd_raddr,
    input  req_ready, rf_we, rf_waddr, rf_wdata, grant_id, commit_cnt,
           fwd_hit, fwd_data, fwd_pending
  );
  modport slave (
    input  req_valid, req_waddr, req_wdata, hold, fwd_raddr,
    output req_ready, rf_we, rf_waddr, rf_wdata, grant_id, commit_cnt,
           fwd_hit, fwd_data, fwd_pending
  );
`else
  modport master (
    output req_valid, req_waddr, req_wdata, hold,
    input  req_ready, rf_we, rf_waddr, rf_wdata, grant_id, commit_cnt
  );
  modport slave (
    input  req_valid, req_waddr, req_wdata, hold,
    output req_ready, rf_we, rf_waddr, rf_wdata, grant_id, commit_cnt
  );
`endif
endinterface

`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
// ============================================================================
// Module   : rf_wb_arbiter
// Purpose  : Round-robin arbiter sharing one register-file write port among
//            NREQ writeback sources; optional forwarding via RF_WB_FWD_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int CW   = 16
) (
  input  logic          clk,
  input  logic          rst,
  rf_wb_arbiter_if.slave bus
);

  localparam int IDW = $clog2(NREQ);
  localparam int SW  = IDW + 1;

  logic [IDW-1:0] rr_ptr_q,     rr_ptr_d;
  logic           rf_we_q,      rf_we_d;
  logic [AW-1:0]  rf_waddr_q,   rf_waddr_d;
  logic [DW-1:0]  rf_wdata_q,   rf_wdata_d;
  logic [IDW-1:0] grant_id_q,   grant_id_d;
  logic [CW-1:0]  commit_cnt_q, commit_cnt_d;

  logic           win_found;
  logic [IDW-1:0] win_idx;
  logic [SW-1:0]  idx_sum;
  logic           accept;
  logic [AW-1:0]  sel_waddr;
  logic [DW-1:0]  sel_wdata;

  // Cyclic search starting at rr_ptr; the extra sum bit absorbs the wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx_sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_sum = {1'b0, rr_ptr_q} + SW'(k);
      if (idx_sum >= SW'(NREQ)) begin
        idx_sum = idx_sum - SW'(NREQ);
      end
      if (!win_found && bus.req_valid[idx_sum[IDW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = idx_sum[IDW-1:0];
      end
    end
  end

  assign accept        = win_found && !bus.hold;
  assign bus.req_ready = accept ? (NREQ'(1) << win_idx) : '0;

  always_comb begin
    sel_waddr = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IDW'(i)) begin
        sel_waddr = bus.req_waddr[i*AW +: AW];
        sel_wdata = bus.req_wdata[i*DW +: DW];
      end
    end
  end

  // $0 writes still consume a grant and advance the pointer, but never reach the file.
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    rf_we_d      = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    grant_id_d   = grant_id_q;
    commit_cnt_d = commit_cnt_q;
    if (accept) begin
      rr_ptr_d   = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);
      grant_id_d = win_idx;
      rf_waddr_d = sel_waddr;
      rf_wdata_d = sel_wdata;
      if (sel_waddr != '0) begin
        rf_we_d      = 1'b1;
        commit_cnt_d = commit_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q     <= '0;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      grant_id_q   <= '0;
      commit_cnt_q <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      grant_id_q   <= grant_id_d;
      commit_cnt_q <= commit_cnt_d;
    end
  end

  assign bus.rf_we      = rf_we_q;
  assign bus.rf_waddr   = rf_waddr_q;
  assign bus.rf_wdata   = rf_wdata_q;
  assign bus.grant_id   = grant_id_q;
  assign bus.commit_cnt = commit_cnt_q;

`ifdef RF_WB_FWD_EN
  logic [NREQ-1:0] pend_match;

  generate
    for (genvar g = 0; g < NREQ; g++) begin : g_fwd_pend
      assign pend_match[g] = bus.req_valid[g] &&
                             (bus.req_waddr[g*AW +: AW] == bus.fwd_raddr);
    end
  endgenerate

  assign bus.fwd_hit     = rf_we_q && (rf_waddr_q == bus.fwd_raddr) && (bus.fwd_raddr != '0);
  assign bus.fwd_data    = bus.fwd_hit ? rf_wdata_q : '0;
  assign bus.fwd_pending = (|pend_match) && (bus.fwd_raddr != '0);
`endif

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
// ============================================================================
// Module   : tb_rf_wb_arbiter
// Purpose  : Directed self-checking bench for rf_wb_arbiter (NREQ=3).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rf_wb_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int CW   = 16;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_miscmp;

  rf_wb_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW), .CW(CW)) bus ();

  rf_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid[i]           = v;
    bus.req_waddr[i*AW +: AW]  = a;
    bus.req_wdata[i*DW +: DW]  = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec         = 0;
    n_miscmp      = 0;
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_waddr = '0;
    bus.req_wdata = '0;
    bus.hold      = 1'b0;
`ifdef RF_WB_FWD_EN
    bus.fwd_raddr = '0;
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("rst_we",    bus.rf_we,      0);
    check_val("rst_waddr", bus.rf_waddr,   0);
    check_val("rst_wdata", bus.rf_wdata,   0);
    check_val("rst_gid",   bus.grant_id,   0);
    check_val("rst_cnt",   bus.commit_cnt, 0);
    check_val("rst_rdy",   bus.req_ready,  0);

    // Single requester
    set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    check_val("s_rdy", bus.req_ready, 3'b001);
    step();
    set_req(0, 1'b0, 5'd0, 32'h0);
    check_val("s_we",    bus.rf_we,      1);
    check_val("s_waddr", bus.rf_waddr,   5);
    check_val("s_wdata", bus.rf_wdata,   32'hDEADBEEF);
    check_val("s_gid",   bus.grant_id,   0);
    check_val("s_cnt",   bus.commit_cnt, 1);
    step();
    check_val("s_we_off", bus.rf_we, 0);

    // All three valid from a fresh reset: 0,1,2,0,1,2
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, AW'(i + 1), 32'h100 + DW'(i));
    #1;
    for (int c = 0; c < 6; c++) begin
      check_val($sformatf("rr_rdy%0d", c), bus.req_ready, 3'b001 << (c % 3));
      step();
      check_val($sformatf("rr_we%0d", c),    bus.rf_we,    1);
      check_val($sformatf("rr_gid%0d", c),   bus.grant_id, c % 3);
      check_val($sformatf("rr_waddr%0d", c), bus.rf_waddr, (c % 3) + 1);
      check_val($sformatf("rr_wdata%0d", c), bus.rf_wdata, 32'h100 + (c % 3));
    end
    check_val("rr_cnt", bus.commit_cnt, 6);

    // $0 write from requester 1
    bus.req_valid = 3'b010;
    set_req(1, 1'b1, 5'd0, 32'h1234);
    #1;
    check_val("z_rdy", bus.req_ready, 3'b010);
    step();
    check_val("z_we",    bus.rf_we,      0);
    check_val("z_cnt",   bus.commit_cnt, 6);
    check_val("z_gid",   bus.grant_id,   1);
    check_val("z_wdata", bus.rf_wdata,   32'h1234);

    // rr_ptr now 2; all valid
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, AW'(i + 1), 32'h200 + DW'(i));
    #1;
    check_val("p2_rdy", bus.req_ready, 3'b100);
    step();
    check_val("p2_gid", bus.grant_id, 2);
    check_val("wrap_rdy", bus.req_ready, 3'b001);
    step();
    check_val("wrap_gid", bus.grant_id, 0);

    // hold while a write is pending
    bus.hold = 1'b1;
    #1;
    check_val("h_rdy0", bus.req_ready, 0);
    check_val("h_pend_we", bus.rf_we, 1);
    for (int c = 0; c < 3; c++) begin
      step();
      check_val($sformatf("h_we%0d", c),  bus.rf_we,     0);
      check_val($sformatf("h_rdy%0d", c), bus.req_ready, 0);
    end
    check_val("h_gid", bus.grant_id,   0);
    check_val("h_cnt", bus.commit_cnt, 8);
    bus.hold = 1'b0;
    #1;
    check_val("h_resume_rdy", bus.req_ready, 3'b010);
    step();
    check_val("h_resume_gid", bus.grant_id, 1);
    check_val("h_resume_we",  bus.rf_we,    1);

    // asynchronous reset mid-stream
    #2;
    rst = 1'b1;
    #1;
    check_val("ar_we",    bus.rf_we,      0);
    check_val("ar_waddr", bus.rf_waddr,   0);
    check_val("ar_wdata", bus.rf_wdata,   0);
    check_val("ar_gid",   bus.grant_id,   0);
    check_val("ar_cnt",   bus.commit_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("ar_rdy", bus.req_ready, 3'b001);
    step();
    check_val("ar_gid2", bus.grant_id,   0);
    check_val("ar_cnt2", bus.commit_cnt, 1);

`ifdef RF_WB_FWD_EN
    bus.req_valid = '0;
    set_req(0, 1'b1, 5'd7, 32'hA5A5A5A5);
    bus.fwd_raddr = 5'd7;
    #1;
    check_val("f_pend7", bus.fwd_pending, 1);
    check_val("f_hit_pre", bus.fwd_hit, 0);
    step();
    bus.req_valid = '0;
    #1;
    check_val("f_hit",  bus.fwd_hit,  1);
    check_val("f_data", bus.fwd_data, 32'hA5A5A5A5);
    bus.fwd_raddr = 5'd0;
    #1;
    check_val("f_hit0",  bus.fwd_hit,  0);
    check_val("f_data0", bus.fwd_data, 0);
    bus.hold = 1'b1;
    set_req(1, 1'b1, 5'd9, 32'h99);
    bus.fwd_raddr = 5'd9;
    #1;
    check_val("f_pend9", bus.fwd_pending, 1);
    bus.fwd_raddr = 5'd10;
    #1;
    check_val("f_pend10", bus.fwd_pending, 0);
    bus.hold = 1'b0;
`endif

    bus.req_valid = '0;
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port among NREQ writeback sources (ALU, load unit, mul/div unit), one write per cycle.
- Arbitration is round-robin with a valid/ready handshake.
- The winning request is registered and drives the register file's we/waddr/wdata one cycle after acceptance.
- Writes to register $0 are accepted and then discarded.

Parameters:
- NREQ, 3, number of writeback requesters (2..8)
- AW, 5, register address width
- DW, 32, register data width
- CW, 16, commit counter width

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- req_valid  input  NREQ  per-requester write request
- req_ready  output  NREQ  per-requester accept; combinational, at most one bit high
- req_waddr  input  NREQ*AW  packed destination addresses; requester i uses bits [i*AW +: AW]
- req_wdata  input  NREQ*DW  packed write data; requester i uses bits [i*DW +: DW]
- hold  input  1  freeze arbitration (pipeline flush or debug)
- rf_we  output  1  register-file write enable, registered
- rf_waddr  output  AW  register-file write address, registered
- rf_wdata  output  DW  register-file write data, registered
- grant_id  output  $clog2(NREQ)  index of the last accepted requester, registered
- commit_cnt  output  CW  count of non-$0 writes issued; wraps at 2^CW

Behaviour:
- Reset (asynchronous, any time): rf_we=0, rf_waddr=0, rf_wdata=0, grant_id=0, commit_cnt=0, rr_ptr=0.
  - An in-flight write held in the output register is lost.
  - After reset, requester 0 has top priority.
- Handshake:
  - A transfer occurs on a rising edge where req_valid[i] && req_ready[i].
  - Requester i holds valid, waddr and wdata stable until accepted.
  - Deasserting valid before acceptance is allowed; the request is withdrawn.
  - req_ready never depends on req_wdata.
- Arbitration (combinational, per cycle):
  - If hold=1, all req_ready=0.
  - Otherwise the winner is the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ..., NREQ-1, 0, ... cyclically.
  - req_ready[winner]=1; all other req_ready bits are 0.
- State update on a clock edge:
  - Accept from winner w: rr_ptr <= (w+1) mod NREQ; grant_id <= w; rf_waddr <= req_waddr[w]; rf_wdata <= req_wdata[w].
    - If req_waddr[w] != 0: rf_we <= 1 and commit_cnt <= commit_cnt+1.
    - Otherwise ($0 write): rf_we <= 0 and commit_cnt is unchanged.
  - No accept (no valid requester, or hold=1): rf_we <= 0. rr_ptr, grant_id, rf_waddr, rf_wdata and commit_cnt hold.
- Latency:
  - Accept edge N puts rf_we high during cycle N+1.
  - The register file captures the write at edge N+1.
  - Back-to-back accepts give rf_we=1 on consecutive cycles, sustaining 1 write/cycle.
- Simultaneous events:
  - Several valid requesters in one cycle: only the winner is accepted; the others wait.
  - Fairness: a continuously valid requester is accepted within NREQ cycles while hold=0.
  - Several requesters with the same waddr are serialized in grant order; the last grant wins in the register file.
  - hold asserted while an output write is pending: the pending rf_we=1 cycle still completes; no new accepts occur.
- rr_ptr wrap-around: after the winner NREQ-1, rr_ptr returns to 0.
- commit_cnt rolls from 2^CW-1 to 0 with no flag.

Optional Feature:
- Macro: RF_WB_FWD_EN.
- When defined, four extra ports exist:
  - fwd_raddr  input  AW  read address to check
  - fwd_hit  output  1  combinational; equals rf_we && (rf_waddr == fwd_raddr) && (fwd_raddr != 0)
  - fwd_data  output  DW  equals rf_wdata when fwd_hit=1, otherwise 0
  - fwd_pending  output  1  combinational; high when any req_valid[i] has req_waddr[i] == fwd_raddr and fwd_raddr != 0
- fwd_hit lets decode take the value being written this cycle; fwd_pending lets decode stall on a not-yet-accepted write.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Single requester: req_valid=001, waddr=5, wdata=0xDEADBEEF -> req_ready=001 same cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, grant_id=0; commit_cnt 0->1.
- All three requesters valid continuously from reset (waddr 1, 2, 3) -> grants in order 0,1,2,0,1,2; rf_we high every cycle; grant_id follows the same sequence.
- Requester 1 writes waddr=0, wdata=0x1234 -> req_ready[1]=1; next cycle rf_we=0; commit_cnt unchanged; rr_ptr advances to 2.
- hold=1 for 3 cycles with all requesters valid -> req_ready=000 and rf_we=0 throughout; on release, the grant resumes at the saved rr_ptr.
- rst pulse mid-stream, asserted asynchronously between edges while rf_we=1 -> rf_we, rf_waddr, rf_wdata, grant_id and commit_cnt read 0 immediately; the first grant after release goes to requester 0.
- With RF_WB_FWD_EN defined:
  - rf_we=1, rf_waddr=7, rf_wdata=0xA5A5A5A5 and fwd_raddr=7 -> fwd_hit=1, fwd_data=0xA5A5A5A5.
  - fwd_raddr=0 -> fwd_hit=0.
  - A pending, not-yet-accepted req_waddr=9 with fwd_raddr=9 -> fwd_pending=1.
